// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner arbiter for a shared W-bit bus with hold timeout and park cycle
module bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         bus_out,
    output logic                 bus_valid,
    output logic                 timeout
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    // Ownership lifecycle: IDLE (nobody asked), GRANT (bus owned), PARK (one dead cycle between owners).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_PARK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            timeout_q, timeout_d;

    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   win_next;
    logic            hold_at_limit;
    logic            owner_req;

    // First requester found scanning upward from p, wrapping at N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(p) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && r[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        return pick;
    endfunction

    // Winner of the current round and the pointer value that demotes it to lowest priority.
    always_comb begin
        win_idx  = rr_pick(req, ptr_q);
        win_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_req     = req[owner_q];
        hold_at_limit = (hold_q == HW'(MAX_HOLD - 1));
    end

    // Next-state and registered-output decisions; arbitration only happens outside GRANT.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_PARK: begin
                if (|req) begin
                    state_d          = ST_GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    owner_d          = win_idx;
                    ptr_d            = win_next;
                    hold_d           = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    owner_d = '0;
                end
            end
            ST_GRANT: begin
                if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + HW'(1);
                end
                if (!owner_req) begin
                    // Voluntary release takes precedence even when the limit is reached.
                    state_d = ST_PARK;
                    gnt_d   = '0;
                    owner_d = '0;
                end else if (hold_at_limit) begin
                    state_d   = ST_PARK;
                    gnt_d     = '0;
                    owner_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = '0;
            end
        endcase
    end

    // State and grant registers; asynchronous reset drops the grant immediately.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // AND-OR bus mux keyed on the one-hot grant so unknowns on idle slices are masked to zero.
    always_comb begin
        bus_out = '0;
        for (int i = 0; i < N; i++) begin
            bus_out = bus_out | (din[i*W +: W] & {W{gnt_q[i]}});
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign bus_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against an ownership model
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 16;

    logic               clk;
    logic               rstb;
    logic [N-1:0]       req;
    logic [N*W-1:0]     din;
    logic [N-1:0]       gnt;
    logic [1:0]         owner;
    logic [W-1:0]       bus_out;
    logic               bus_valid;
    logic               timeout;

    int vectors;
    int miscompares;

    // Reference model: current owner (-1 = none), cycles owned so far, next highest-priority index.
    int m_cur;
    int m_run;
    int m_prio;
    bit m_to;

    bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .owner     (owner),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_cur  = -1;
        m_run  = 0;
        m_prio = 0;
        m_to   = 1'b0;
    endtask

    task automatic m_update(input logic [N-1:0] r);
        bit found;
        int i;
        m_to  = 1'b0;
        found = 1'b0;
        if (m_cur >= 0) begin
            if (r[m_cur] !== 1'b1) begin
                m_cur = -1;
            end else if (m_run == MAX_HOLD) begin
                m_cur = -1;
                m_to  = 1'b1;
            end else begin
                m_run++;
            end
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                i = (m_prio + k) % N;
                if (!found && r[i]) begin
                    found  = 1'b1;
                    m_cur  = i;
                    m_run  = 1;
                    m_prio = (i + 1) % N;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        int           eo;
        eg = '0;
        eb = '0;
        eo = 0;
        if (m_cur >= 0) begin
            eg[m_cur] = 1'b1;
            eb        = din[m_cur*W +: W];
            eo        = m_cur;
        end
        chk({tag, "_gnt"},     32'(gnt),       32'(eg));
        chk({tag, "_owner"},   32'(owner),     32'(eo));
        chk({tag, "_bus_out"}, 32'(bus_out),   32'(eb));
        chk({tag, "_valid"},   32'(bus_valid), 32'(eg != '0));
        chk({tag, "_timeout"}, 32'(timeout),   32'(m_to));
        chk({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'(1));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rstb) m_update(req);
        else      m_reset();
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset();
        rstb = 1'b0;
        req  = '0;
        @(posedge clk);
        #1;
        m_reset();
        check_all("reset");
        rstb = 1'b1;
    endtask

    // Random data on requesting slices and on the current owner; unknown elsewhere.
    task automatic drive_din_masked();
        for (int i = 0; i < N; i++) begin
            if (req[i] || i == m_cur) din[i*W +: W] = W'($urandom);
            else                      din[i*W +: W] = 'x;
        end
    endtask

    initial begin
        int order[8];
        int got;
        int cnt;
        int cnt0;
        int cnt3;
        logic [N-1:0] nreq;
        logic [W-1:0] slice2;

        vectors     = 0;
        miscompares = 0;
        rstb        = 1'b0;
        req         = '0;
        din         = '0;
        m_reset();

        // Single requester from idle, then release through park to idle.
        apply_reset();
        din    = 32'hA1B2C3D4;
        slice2 = din[23:16];
        req    = 4'b0100;
        step("t1_grant");
        chk("t1_gnt_const",   32'(gnt),     32'h4);
        chk("t1_owner_const", 32'(owner),   32'd2);
        chk("t1_bus_const",   32'(bus_out), 32'(slice2));
        req = 4'b0000;
        step("t1_park");
        chk("t1_park_gnt", 32'(gnt), 32'h0);
        step("t1_idle");

        // All requesting with one-cycle transfers: rotation 0,1,2,3,0.
        apply_reset();
        din = {$urandom};
        req = 4'b1111;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            step("t2");
            if (gnt != '0) begin
                order[got] = int'(owner);
                got++;
                req = 4'b1111 & ~gnt;
            end else begin
                req = 4'b1111;
            end
        end
        chk("t2_count", 32'(got), 32'd5);
        chk("t2_o0", 32'(order[0]), 32'd0);
        chk("t2_o1", 32'(order[1]), 32'd1);
        chk("t2_o2", 32'(order[2]), 32'd2);
        chk("t2_o3", 32'(order[3]), 32'd3);
        chk("t2_o4", 32'(order[4]), 32'd0);

        // Single requester holding forever: 16-cycle grant, timeout pulse, park, regrant.
        apply_reset();
        req = 4'b0001;
        step("t3");
        cnt = 0;
        while (cnt < 20 && gnt == 4'b0001) begin
            cnt++;
            step("t3");
        end
        chk("t3_hold_len",  32'(cnt),     32'd16);
        chk("t3_timeout",   32'(timeout), 32'd1);
        chk("t3_park_gnt",  32'(gnt),     32'h0);
        step("t3_regrant");
        chk("t3_regrant_gnt", 32'(gnt),   32'h1);
        chk("t3_to_clear",  32'(timeout), 32'd0);

        // Two long holders: alternate, neither starves.
        apply_reset();
        req  = 4'b1001;
        got  = 0;
        cnt0 = 0;
        cnt3 = 0;
        for (int c = 0; c < 100; c++) begin
            step("t4");
            if (gnt != '0 && m_run == 1) begin
                if (got < 8) order[got] = int'(owner);
                got++;
                if (owner == 2'd0) cnt0++;
                if (owner == 2'd3) cnt3++;
            end
        end
        chk("t4_first",  32'(order[0]), 32'd0);
        chk("t4_second", 32'(order[1]), 32'd3);
        chk("t4_third",  32'(order[2]), 32'd0);
        chk("t4_grants0", 32'(cnt0 >= 2), 32'd1);
        chk("t4_grants3", 32'(cnt3 >= 2), 32'd1);

        // Asynchronous reset in the middle of a grant to owner 1.
        apply_reset();
        din = {$urandom};
        req = 4'b0010;
        step("t5_grant");
        step("t5_hold");
        chk("t5_owner_pre", 32'(owner), 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        m_reset();
        check_all("t5_async");
        chk("t5_gnt0", 32'(gnt),     32'h0);
        chk("t5_bus0", 32'(bus_out), 32'h0);
        step("t5_in_reset");
        rstb = 1'b1;
        req  = 4'b1111;
        step("t5_after");
        chk("t5_first_owner", 32'(gnt), 32'h1);

        // Owner drops request exactly on the last allowed cycle: normal release.
        apply_reset();
        req = 4'b0100;
        step("t6_grant");
        for (int c = 0; c < MAX_HOLD - 1; c++) step("t6_hold");
        chk("t6_still_owned", 32'(gnt), 32'h4);
        req = 4'b0000;
        step("t6_release");
        chk("t6_no_timeout", 32'(timeout), 32'd0);
        chk("t6_park_gnt",   32'(gnt),     32'h0);
        step("t6_idle");

        // Randomized traffic with unknown data on non-requesting slices.
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            nreq = req;
            for (int i = 0; i < N; i++) begin
                if (nreq[i]) begin
                    if ($urandom_range(0, 7) == 0) nreq[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    nreq[i] = 1'b1;
                end
            end
            req = nreq;
            drive_din_masked();
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
